// File: rtl/array_wr_ctrl_page.sv
`default_nettype none
// ============================================================================
// array_wr_ctrl_page : open-page write controller for one DRAM-style bank
// Rev 1.0
// ============================================================================
module array_wr_ctrl_page #(
    parameter int ADDR_WIDTH  = 20,
    parameter int DATA_WIDTH  = 64,
    parameter int RADDR_WIDTH = 14,
    parameter int CADDR_WIDTH = ADDR_WIDTH - RADDR_WIDTH,
    parameter int FRAME_WIDTH = ADDR_WIDTH + DATA_WIDTH + 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             mc_tras_cfg,
    input  logic [7:0]             mc_trp_cfg,
    input  logic [7:0]             mc_trcd_cfg,
    input  logic [7:0]             mc_twr_cfg,
    input  logic [7:0]             mc_page_idle_cfg,
    input  logic [FRAME_WIDTH-1:0] axi_frame_wr_data,
    input  logic                   axi_frame_wr_valid,
    output logic                   axi_frame_wr_ready,
    input  logic                   close_req,
    output logic                   wr_done,
    output logic                   bank_open,
    output logic                   page_hit,
    output logic                   array_banksel_n_wr,
    output logic [RADDR_WIDTH-1:0] array_raddr_wr,
    output logic                   array_cas_wr,
    output logic [CADDR_WIDTH-1:0] array_caddr_wr,
    output logic [DATA_WIDTH-1:0]  array_wdata,
    output logic                   array_wdata_rdy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ACT    = 3'd1;
    localparam logic [2:0] S_W_TRCD = 3'd2;
    localparam logic [2:0] S_WDATA  = 3'd3;
    localparam logic [2:0] S_WLAST  = 3'd4;
    localparam logic [2:0] S_W_TWR  = 3'd5;
    localparam logic [2:0] S_OPEN   = 3'd6;
    localparam logic [2:0] S_W_TRP  = 3'd7;

    logic [2:0]             state, state_next;
    logic [7:0]             cnt, tras_cnt;
    logic                   single_flag, pend, close_done;

    logic                   f_sof, f_eof;
    logic [RADDR_WIDTH-1:0] f_row;
    logic [CADDR_WIDTH-1:0] f_col;
    logic [DATA_WIDTH-1:0]  f_data;
    logic                   accept, row_hit, hit_accept, miss_accept;
    logic [7:0]             trcd_eff, twr_eff, tras_eff, trp_eff;
    logic                   trcd_last, twr_exit, trp_last, idle_to, row_active;
    logic                   unused_rsvd;

    assign f_sof       = axi_frame_wr_data[FRAME_WIDTH-1];
    assign f_eof       = axi_frame_wr_data[FRAME_WIDTH-2];
    assign unused_rsvd = axi_frame_wr_data[FRAME_WIDTH-3];
    assign f_row       = axi_frame_wr_data[DATA_WIDTH+ADDR_WIDTH-1 -: RADDR_WIDTH];
    assign f_col       = axi_frame_wr_data[DATA_WIDTH+CADDR_WIDTH-1 -: CADDR_WIDTH];
    assign f_data      = axi_frame_wr_data[DATA_WIDTH-1:0];

    assign accept      = axi_frame_wr_valid & axi_frame_wr_ready;
    assign row_hit     = (f_row == array_raddr_wr);
    assign hit_accept  = (state == S_OPEN) & accept & f_sof & row_hit;
    assign miss_accept = (state == S_OPEN) & accept & f_sof & ~row_hit;

    // A programmed timing of zero behaves as one cycle.
    assign trcd_eff = (mc_trcd_cfg == 8'd0) ? 8'd1 : mc_trcd_cfg;
    assign twr_eff  = (mc_twr_cfg  == 8'd0) ? 8'd1 : mc_twr_cfg;
    assign tras_eff = (mc_tras_cfg == 8'd0) ? 8'd1 : mc_tras_cfg;
    assign trp_eff  = (mc_trp_cfg  == 8'd0) ? 8'd1 : mc_trp_cfg;

    assign trcd_last = (cnt >= trcd_eff - 8'd1);
    assign twr_exit  = (cnt >= twr_eff - 8'd1) && (tras_cnt >= tras_eff - 8'd1);
    assign trp_last  = (cnt >= trp_eff - 8'd1);
    assign idle_to   = (mc_page_idle_cfg == 8'd0) || (cnt >= mc_page_idle_cfg - 8'd1);

    assign row_active = (state == S_W_TRCD) || (state == S_WDATA) || (state == S_WLAST) ||
                        (state == S_W_TWR)  || (state == S_OPEN);

    assign bank_open       = ~array_banksel_n_wr;
    assign array_wdata_rdy = ~array_cas_wr;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (axi_frame_wr_valid && f_sof) state_next = S_ACT;
            S_ACT:    state_next = S_W_TRCD;
            S_W_TRCD: if (trcd_last) state_next = single_flag ? S_WLAST : S_WDATA;
            S_WDATA:  if (accept && f_eof) state_next = S_WLAST;
            S_WLAST:  state_next = S_W_TWR;
            S_W_TWR:  if (twr_exit) state_next = (mc_page_idle_cfg == 8'd0) ? S_W_TRP : S_OPEN;
            S_OPEN: begin
                if (close_req)
                    state_next = S_W_TRP;
                else if (axi_frame_wr_valid && f_sof)
                    state_next = row_hit ? (f_eof ? S_WLAST : S_WDATA) : S_W_TRP;
                else if (idle_to)
                    state_next = S_W_TRP;
            end
            S_W_TRP:  if (trp_last) state_next = pend ? S_ACT : S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        axi_frame_wr_ready = 1'b0;
        wr_done            = 1'b0;
        page_hit           = 1'b0;
        case (state)
            S_IDLE:  axi_frame_wr_ready = 1'b1;
            S_WDATA: axi_frame_wr_ready = ~array_cas_wr;
            S_OPEN: begin
                axi_frame_wr_ready = ~close_req;
                page_hit           = ~close_req & axi_frame_wr_valid & f_sof & row_hit;
            end
            S_W_TWR: wr_done = twr_exit && (mc_page_idle_cfg != 8'd0);
            S_W_TRP: wr_done = trp_last && close_done;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            array_banksel_n_wr <= 1'b1;
            array_raddr_wr     <= '0;
            array_caddr_wr     <= '0;
            array_wdata        <= '0;
            array_cas_wr       <= 1'b0;
            single_flag        <= 1'b0;
            pend               <= 1'b0;
            close_done         <= 1'b0;
            cnt                <= 8'd0;
            tras_cnt           <= 8'd0;
        end else begin
            if (state == S_ACT)
                array_banksel_n_wr <= 1'b0;
            else if (state != S_W_TRP && state_next == S_W_TRP)
                array_banksel_n_wr <= 1'b1;

            if ((state == S_W_TRCD && trcd_last) || hit_accept)
                array_cas_wr <= 1'b1;
            else if (state == S_WDATA)
                array_cas_wr <= ~array_cas_wr & axi_frame_wr_valid;
            else if (state == S_WLAST)
                array_cas_wr <= 1'b0;

            if (accept && (state == S_IDLE || state == S_OPEN || state == S_WDATA)) begin
                array_caddr_wr <= f_col;
                array_wdata    <= f_data;
            end
            // Row address only moves when the bank is closed or about to be reopened.
            if (accept && f_sof && (state == S_IDLE || state == S_OPEN)) begin
                single_flag <= f_eof;
                if (state == S_IDLE || !row_hit)
                    array_raddr_wr <= f_row;
            end

            if (miss_accept)
                pend <= 1'b1;
            else if (state == S_W_TRP && trp_last)
                pend <= 1'b0;

            if (state == S_W_TWR && state_next == S_W_TRP)
                close_done <= 1'b1;
            else if (state == S_W_TRP && trp_last)
                close_done <= 1'b0;

            if (state_next != state)
                cnt <= 8'd0;
            else if (cnt != 8'hFF)
                cnt <= cnt + 8'd1;

            if (!row_active)
                tras_cnt <= 8'd0;
            else if (tras_cnt != 8'hFF)
                tras_cnt <= tras_cnt + 8'd1;
        end
    end

endmodule
`default_nettype wire
